instr_decode_stage: RTL and testbench

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

---
 rtl/instr_decode_stage.sv | 155 +++++++++++++++
 tb/tb_instr_decode_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// Instruction decode stage.
// Splits an instruction word into opcode / mem-op / left / right fields and
// registers them behind a valid/ready handshake. A prefix word (opcode ==
// PFX_OPC) is absorbed without producing output. Its operand becomes the upper
// half of the immediate for the next ordinary word.
module instr_decode_stage #(
   parameter int               INSTR_W = 16,
   parameter int               FLD_W   = 4,
   parameter bit               EXT_EN  = 1'b1,
   parameter logic [FLD_W-1:0] PFX_OPC = 4'hF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [INSTR_W-1:0]   instr,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [FLD_W-1:0]     op_code,
   output logic [FLD_W-1:0]     mem_op,
   output logic [FLD_W-1:0]     left_operand,
   output logic [FLD_W-1:0]     right_operand,
   output logic [2*FLD_W-1:0]   operand,
   output logic [4*FLD_W-1:0]   imm_ext,
   output logic                 imm_is_ext,
   output logic                 pfx_err
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PFX  = 1'b1
   } state_t;

   // The field split only makes sense when the word is exactly four fields wide.
   if (INSTR_W != 4*FLD_W) begin : g_width_check
      $error("instr_decode_stage: INSTR_W must equal 4*FLD_W");
   end

   // Incoming word broken into its fields.
   logic [FLD_W-1:0]   in_op;
   logic [FLD_W-1:0]   in_mem;
   logic [FLD_W-1:0]   in_left;
   logic [FLD_W-1:0]   in_right;
   logic [2*FLD_W-1:0] in_operand;
   logic               in_is_pfx;
   logic               accept;
   logic               xfer;

   state_t             state_q, state_d;
   logic [2*FLD_W-1:0] pfx_q, pfx_d;
   logic               valid_d;
   logic               pfx_err_d;
   logic [FLD_W-1:0]   op_d, mem_d, left_d, right_d;
   logic [4*FLD_W-1:0] imm_d;
   logic               imm_is_ext_d;

   assign in_op      = instr[4*FLD_W-1:3*FLD_W];
   assign in_mem     = instr[3*FLD_W-1:2*FLD_W];
   assign in_left    = instr[2*FLD_W-1:FLD_W];
   assign in_right   = instr[FLD_W-1:0];
   assign in_operand = {in_left, in_right};

   // A prefix opcode is only special when extension is built in.
   assign in_is_pfx = EXT_EN && (in_op == PFX_OPC);

   // Ready whenever the output register is free or draining this cycle.
   // Flush blocks acceptance.
   assign in_ready = (!out_valid || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;

   assign operand  = {left_operand, right_operand};

   // Next-state and next-output decode.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      pfx_d        = pfx_q;
      valid_d      = out_valid;
      pfx_err_d    = 1'b0;
      op_d         = op_code;
      mem_d        = mem_op;
      left_d       = left_operand;
      right_d      = right_operand;
      imm_d        = imm_ext;
      imm_is_ext_d = imm_is_ext;

      if (flush) begin
         state_d = S_IDLE;
         pfx_d   = '0;
         valid_d = 1'b0;
      end else begin
         if (xfer) begin
            valid_d = 1'b0;
         end
         if (accept) begin
            if (in_is_pfx) begin
               // Prefix: remember its operand. A second prefix in a row
               // overwrites the first one and raises an error pulse.
               pfx_d     = in_operand;
               state_d   = S_PFX;
               pfx_err_d = (state_q == S_PFX);
            end else begin
               op_d    = in_op;
               mem_d   = in_mem;
               left_d  = in_left;
               right_d = in_right;
               valid_d = 1'b1;
               if (state_q == S_PFX) begin
                  imm_d        = {pfx_q, in_operand};
                  imm_is_ext_d = 1'b1;
               end else begin
                  imm_d        = {{(2*FLD_W){1'b0}}, in_operand};
                  imm_is_ext_d = 1'b0;
               end
               state_d = S_IDLE;
               pfx_d   = '0;
            end
         end
      end
   end

   // State, pending prefix and registered output fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pfx_q         <= '0;
         out_valid     <= 1'b0;
         pfx_err       <= 1'b0;
         op_code       <= '0;
         mem_op        <= '0;
         left_operand  <= '0;
         right_operand <= '0;
         imm_ext       <= '0;
         imm_is_ext    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make all registers update together
         // from pre-edge values. This is what keeps the simulation free of
         // ordering races.
         state_q       <= state_d;
         pfx_q         <= pfx_d;
         out_valid     <= valid_d;
         pfx_err       <= pfx_err_d;
         op_code       <= op_d;
         mem_op        <= mem_d;
         left_operand  <= left_d;
         right_operand <= right_d;
         imm_ext       <= imm_d;
         imm_is_ext    <= imm_is_ext_d;
      end
   end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage.
// Expected outputs are pushed into a scoreboard queue as words are sent. They
// are compared against the held output on every cycle that valid is high, and
// popped when the consumer takes the output or a flush discards it.
module tb_instr_decode_stage;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  mem;
      logic [3:0]  l;
      logic [3:0]  r;
      logic [15:0] imm;
      logic        ext;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [15:0] instr;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  op_code, mem_op, left_operand, right_operand;
   logic [7:0]  operand;
   logic [15:0] imm_ext;
   logic        imm_is_ext;
   logic        pfx_err;

   // Second instance built without prefix extension.
   logic        n_in_valid;
   logic [15:0] n_instr;
   logic        n_in_ready;
   logic        n_out_valid;
   logic        n_out_ready;
   logic [3:0]  n_op_code, n_mem_op, n_left, n_right;
   logic [7:0]  n_operand;
   logic [15:0] n_imm_ext;
   logic        n_imm_is_ext;
   logic        n_pfx_err;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   // Reference state tracked by the bench.
   logic m_valid = 1'b0;
   logic m_pfx   = 1'b0;
   logic m_perr  = 1'b0;

   instr_decode_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .instr         (instr),
      .in_ready      (in_ready),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .op_code       (op_code),
      .mem_op        (mem_op),
      .left_operand  (left_operand),
      .right_operand (right_operand),
      .operand       (operand),
      .imm_ext       (imm_ext),
      .imm_is_ext    (imm_is_ext),
      .pfx_err       (pfx_err)
   );

   instr_decode_stage #(.EXT_EN(1'b0)) dut_noext (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (1'b0),
      .in_valid      (n_in_valid),
      .instr         (n_instr),
      .in_ready      (n_in_ready),
      .out_valid     (n_out_valid),
      .out_ready     (n_out_ready),
      .op_code       (n_op_code),
      .mem_op        (n_mem_op),
      .left_operand  (n_left),
      .right_operand (n_right),
      .operand       (n_operand),
      .imm_ext       (n_imm_ext),
      .imm_is_ext    (n_imm_is_ext),
      .pfx_err       (n_pfx_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [3:0] op, input logic [3:0] mem, input logic [3:0] l,
                           input logic [3:0] r, input logic [15:0] imm, input logic ext);
      exp_t e;
      e.op  = op;
      e.mem = mem;
      e.l   = l;
      e.r   = r;
      e.imm = imm;
      e.ext = ext;
      sb.push_back(e);
   endtask

   task automatic drive(input logic v, input logic [15:0] w, input logic rdy, input logic fl);
      in_valid  = v;
      instr     = w;
      out_ready = rdy;
      flush     = fl;
   endtask

   // One clock cycle. It is entered just after a falling edge, with the inputs
   // already driven, and it returns at the next falling edge.
   task automatic cycle(output bit acc);
      bit   exp_rdy;
      bit   is_pfx;
      exp_t e;
      #1;
      exp_rdy = (!m_valid || out_ready) && !flush;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         check("sb_entry", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb[0];
            check("op_code", 32'(op_code), 32'(e.op));
            check("mem_op", 32'(mem_op), 32'(e.mem));
            check("left_operand", 32'(left_operand), 32'(e.l));
            check("right_operand", 32'(right_operand), 32'(e.r));
            check("operand", 32'(operand), 32'({e.l, e.r}));
            check("imm_ext", 32'(imm_ext), 32'(e.imm));
            check("imm_is_ext", 32'(imm_is_ext), 32'(e.ext));
            if (flush || out_ready) void'(sb.pop_front());
         end
      end
      acc    = in_valid && exp_rdy;
      is_pfx = (instr[15:12] == 4'hF);
      if (flush) begin
         m_valid = 1'b0;
         m_pfx   = 1'b0;
         m_perr  = 1'b0;
      end else begin
         m_perr = 1'b0;
         if (m_valid && out_ready) m_valid = 1'b0;
         if (acc) begin
            if (is_pfx) begin
               m_perr = m_pfx;
               m_pfx  = 1'b1;
            end else begin
               m_valid = 1'b1;
               m_pfx   = 1'b0;
            end
         end
      end
      @(negedge clk);
      check("pfx_err", 32'(pfx_err), 32'(m_perr));
   endtask

   // Present a word until it is accepted, with a bounded number of attempts.
   task automatic send(input logic [15:0] w, input logic rdy);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 20) begin
         drive(1'b1, w, rdy, 1'b0);
         cycle(acc);
         n++;
      end
      check("send_accepted", 32'(acc), 32'd1);
   endtask

   task automatic idle(input int cycles);
      bit acc;
      for (int i = 0; i < cycles; i++) begin
         drive(1'b0, 16'h0000, 1'b1, 1'b0);
         cycle(acc);
      end
   endtask

   task automatic reset_model();
      m_valid = 1'b0;
      m_pfx   = 1'b0;
      m_perr  = 1'b0;
      sb.delete();
   endtask

   initial begin
      bit          acc;
      logic [15:0] w;
      int          n;

      rst_n       = 1'b0;
      n_in_valid  = 1'b0;
      n_instr     = 16'h0000;
      n_out_ready = 1'b1;
      drive(1'b0, 16'h0000, 1'b0, 1'b0);

      // Reset state.
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_pfx_err", 32'(pfx_err), 32'd0);
      check("rst_imm_ext", 32'(imm_ext), 32'd0);
      check("rst_op_code", 32'(op_code), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Single word.
      push_exp(4'h3, 4'hA, 4'h5, 4'hC, 16'h005C, 1'b0);
      send(16'h3A5C, 1'b1);
      idle(1);

      // Prefix pair: no output for the prefix word.
      send(16'hF012, 1'b1);
      push_exp(4'h1, 4'h2, 4'h3, 4'h4, 16'h1234, 1'b1);
      send(16'h1234, 1'b1);
      idle(1);

      // Double prefix: error pulse, and the second prefix wins.
      send(16'hF0AA, 1'b1);
      send(16'hF0BB, 1'b1);
      push_exp(4'h2, 4'h0, 4'h3, 4'h3, 16'hBB33, 1'b1);
      send(16'h2033, 1'b1);
      idle(2);

      // Backpressure: consumer stalls for 3 cycles after the first word.
      push_exp(4'h1, 4'h0, 4'h0, 4'h1, 16'h0001, 1'b0);
      drive(1'b1, 16'h1001, 1'b1, 1'b0);
      cycle(acc);
      check("bp_first_acc", 32'(acc), 32'd1);
      push_exp(4'h2, 4'h0, 4'h0, 4'h2, 16'h0002, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h2002, 1'b0, 1'b0);
         cycle(acc);
      end
      drive(1'b1, 16'h2002, 1'b1, 1'b0);
      cycle(acc);
      check("bp_second_acc", 32'(acc), 32'd1);
      push_exp(4'h3, 4'h0, 4'h0, 4'h3, 16'h0003, 1'b0);
      drive(1'b1, 16'h3003, 1'b1, 1'b0);
      cycle(acc);
      check("bp_third_acc", 32'(acc), 32'd1);
      idle(2);
      check("bp_drained", 32'(sb.size()), 32'd0);

      // A prefix accepted while the output transfers clears out_valid.
      push_exp(4'h7, 4'h0, 4'h0, 4'h1, 16'h0001, 1'b0);
      send(16'h7001, 1'b1);
      send(16'hF0CC, 1'b1);
      push_exp(4'h8, 4'h0, 4'h0, 4'h2, 16'hCC02, 1'b1);
      send(16'h8002, 1'b1);
      idle(1);

      // Flush discards a pending prefix.
      send(16'hF077, 1'b1);
      drive(1'b0, 16'h0000, 1'b1, 1'b1);
      cycle(acc);
      push_exp(4'h4, 4'h0, 4'h1, 4'h1, 16'h0011, 1'b0);
      send(16'h4011, 1'b1);
      idle(1);

      // Flush discards a held output and blocks a simultaneous word.
      push_exp(4'h9, 4'h0, 4'h0, 4'h9, 16'h0009, 1'b0);
      send(16'h9009, 1'b0);
      drive(1'b1, 16'hA00A, 1'b0, 1'b1);
      cycle(acc);
      check("flush_blocks_accept", 32'(acc), 32'd0);
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      cycle(acc);
      check("flush_sb_empty", 32'(sb.size()), 32'd0);

      // Asynchronous reset pulse mid-cycle while an output is held.
      push_exp(4'h5, 4'h0, 4'h6, 4'h6, 16'h0066, 1'b0);
      send(16'h5066, 1'b0);
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_op_code", 32'(op_code), 32'd0);
      check("arst_operand", 32'(operand), 32'd0);
      check("arst_imm_ext", 32'(imm_ext), 32'd0);
      check("arst_imm_is_ext", 32'(imm_is_ext), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();

      // Reset in the middle of a prefix discards that prefix.
      send(16'hF055, 1'b1);
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
      push_exp(4'h6, 4'h0, 4'h7, 4'h7, 16'h0077, 1'b0);
      send(16'h6077, 1'b1);
      idle(1);

      // Random non-prefix stream with a randomly stalling consumer.
      for (int k = 0; k < 8; k++) begin
         w = {4'($urandom_range(0, 14)), 12'($urandom())};
         push_exp(w[15:12], w[11:8], w[7:4], w[3:0], {8'h00, w[7:0]}, 1'b0);
         acc = 1'b0;
         n   = 0;
         while (!acc && n < 20) begin
            drive(1'b1, w, 1'($urandom_range(0, 1)), 1'b0);
            cycle(acc);
            n++;
         end
         check("rand_accepted", 32'(acc), 32'd1);
      end
      idle(3);
      check("rand_drained", 32'(sb.size()), 32'd0);

      // Build without extension: a prefix opcode decodes as an ordinary word.
      n_in_valid = 1'b1;
      n_instr    = 16'hF012;
      @(posedge clk);
      #1;
      check("noext_valid", 32'(n_out_valid), 32'd1);
      check("noext_op_code", 32'(n_op_code), 32'hF);
      check("noext_imm_ext", 32'(n_imm_ext), 32'h0012);
      check("noext_is_ext", 32'(n_imm_is_ext), 32'd0);
      @(negedge clk);
      n_instr = 16'hF034;
      @(posedge clk);
      #1;
      check("noext_op_code2", 32'(n_op_code), 32'hF);
      check("noext_imm_ext2", 32'(n_imm_ext), 32'h0034);
      check("noext_pfx_err", 32'(n_pfx_err), 32'd0);
      n_in_valid = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
